// File: rtl/msa3_pkg.sv
// ---------------------------------------------------------------------------
// | msa3_pkg : shared types and cost helpers for the 3-sequence aligner     |
// | Rev 1.0  : initial release                                              |
// ---------------------------------------------------------------------------
`default_nettype none

package msa3_pkg;

  localparam int NSLOT = 7;

  typedef enum logic [2:0] {M = 3'd0, IXY, IYZ, IXZ, IX, IY, IZ} slot_e;
  typedef enum logic [1:0] {AX_X = 2'd0, AX_Y, AX_Z} axis_e;

  function automatic int neg_inf(input int w);
    return -(1 << (w - 1));
  endfunction

  // Extending the gap on the same axis costs 2GE, opening on both pairs costs 2G0.
  function automatic int penalty(input axis_e axis, input slot_e slot, input int g0, input int ge);
    int p_oo;
    int p_oe;
    int p_ee;
    p_oo = 2 * g0;
    p_oe = g0 + ge;
    p_ee = 2 * ge;
    penalty = p_oe;
    case (axis)
      AX_X: begin
        if (slot == M || slot == IYZ) penalty = p_oo;
        else if (slot == IX)          penalty = p_ee;
      end
      AX_Y: begin
        if (slot == M || slot == IXZ) penalty = p_oo;
        else if (slot == IY)          penalty = p_ee;
      end
      default: begin
        if (slot == M || slot == IXY) penalty = p_oo;
        else if (slot == IZ)          penalty = p_ee;
      end
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/msa3_gap_cell_max7_arg.sv
// ---------------------------------------------------------------------------
// | max7_arg : 7-input signed maximum, lowest index wins on ties            |
// | Rev 1.0  : initial release                                              |
// ---------------------------------------------------------------------------
`default_nettype none

module max7_arg
  import msa3_pkg::*;
#(
  parameter int W = 12
) (
  input  logic        [NSLOT-1:0][W-1:0] cand,
  output logic signed [W-1:0]            max_val,
  output logic        [2:0]              arg
);

  // Strict compare keeps the earlier index on equal values.
  always_comb begin
    max_val = $signed(cand[0]);
    arg     = 3'd0;
    for (int i = 1; i < NSLOT; i++) begin
      if ($signed(cand[i]) > max_val) begin
        max_val = $signed(cand[i]);
        arg     = 3'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/msa3_gap_cell.sv
// ---------------------------------------------------------------------------
// | msa3_gap_cell : pipelined Ix/Iy/Iz gap-state cell with traceback        |
// | Rev 1.0       : initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module msa3_gap_cell
  import msa3_pkg::*;
#(
  parameter int W  = 12,
  parameter int G0 = 2,
  parameter int GE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NSLOT*W-1:0]   nb_x,
  input  logic [NSLOT*W-1:0]   nb_y,
  input  logic [NSLOT*W-1:0]   nb_z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  ix_out,
  output logic signed [W-1:0]  iy_out,
  output logic signed [W-1:0]  iz_out,
  output logic [2:0]           tb_x,
  output logic [2:0]           tb_y,
  output logic [2:0]           tb_z
);

  localparam logic signed [W+1:0] c_neg_ext = (W+2)'(neg_inf(W));
  localparam logic        [W-1:0] c_neg_w   = W'(neg_inf(W));

  logic [2:0][NSLOT*W-1:0]      w_bus;
  logic [2:0][NSLOT-1:0][W-1:0] w_cand;
  logic [2:0][NSLOT-1:0][W-1:0] r_cand;
  logic [2:0][W-1:0]            w_max;
  logic [2:0][2:0]              w_arg;
  logic [2:0][W-1:0]            r_score;
  logic [2:0][2:0]              r_ptr;
  logic                         r_s1_valid;
  logic                         r_s2_valid;
  logic                         w_s2_ready;
  logic                         w_in_fire;

  assign w_bus = {nb_z, nb_y, nb_x};

  // Clamped subtractors: an input at minus infinity stays there, anything
  // that would fall below it saturates instead of wrapping.
  for (genvar a = 0; a < 3; a++) begin : g_axis
    for (genvar s = 0; s < NSLOT; s++) begin : g_slot
      localparam logic signed [W+1:0] c_pen =
        (W+2)'(penalty(axis_e'(a), slot_e'(s), G0, GE));
      logic        [W-1:0] w_slot;
      logic signed [W+1:0] w_ext;
      logic signed [W+1:0] w_diff;
      assign w_slot = w_bus[a][s*W +: W];
      assign w_ext  = {{2{w_slot[W-1]}}, w_slot};
      assign w_diff = w_ext - c_pen;
      assign w_cand[a][s] = (w_slot == c_neg_w || w_diff < c_neg_ext) ? c_neg_w : w_diff[W-1:0];
    end
  end

  assign w_s2_ready = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;
  assign w_in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_cand     <= '0;
    end else begin
      if (in_ready)  r_s1_valid <= in_valid;
      if (w_in_fire) r_cand     <= w_cand;
    end
  end

  for (genvar a = 0; a < 3; a++) begin : g_max
    max7_arg #(.W(W)) u_max (
      .cand    (r_cand[a]),
      .max_val (w_max[a]),
      .arg     (w_arg[a])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_score    <= '0;
      r_ptr      <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_score <= w_max;
        r_ptr   <= w_arg;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign ix_out    = r_score[0];
  assign iy_out    = r_score[1];
  assign iz_out    = r_score[2];
  assign tb_x      = r_ptr[0];
  assign tb_y      = r_ptr[1];
  assign tb_z      = r_ptr[2];

endmodule

`default_nettype wire

// File: tb/tb_msa3_gap_cell.sv
// ---------------------------------------------------------------------------
// | tb_msa3_gap_cell : directed and streamed checks of msa3_gap_cell        |
// | Rev 1.0          : initial release                                      |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_msa3_gap_cell;

  localparam int W  = 12;
  localparam int NI = -2048;
  localparam int BW = 7 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [BW-1:0] nb_x = '0;
  logic [BW-1:0] nb_y = '0;
  logic [BW-1:0] nb_z = '0;
  logic signed [W-1:0] ix_out, iy_out, iz_out;
  logic [2:0]    tb_x, tb_y, tb_z;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int n_out    = 0;
  logic [44:0] expq[$];
  logic        hold_v = 1'b0;
  logic [44:0] hold_d = '0;

  // Hand-derived penalties for G0=2, GE=1: 2G0=4, G0+GE=3, 2GE=2.
  int pen_tab [3][7] = '{'{4,3,4,3,2,3,3}, '{4,3,3,4,3,2,3}, '{4,4,3,3,3,3,2}};

  msa3_gap_cell #(.W(W), .G0(2), .GE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .nb_x(nb_x), .nb_y(nb_y), .nb_z(nb_z), .out_valid(out_valid), .out_ready(out_ready),
    .ix_out(ix_out), .iy_out(iy_out), .iz_out(iz_out), .tb_x(tb_x), .tb_y(tb_y), .tb_z(tb_z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] bus_fill(input int v);
    logic [BW-1:0] b;
    for (int s = 0; s < 7; s++) b[s*W +: W] = W'(v);
    return b;
  endfunction

  function automatic logic [BW-1:0] set_slot(input logic [BW-1:0] b, input int s, input int v);
    logic [BW-1:0] r;
    r = b;
    r[s*W +: W] = W'(v);
    return r;
  endfunction

  function automatic void eval_axis(input logic [BW-1:0] b, input int a, output int sc, output int pt);
    int v;
    int c;
    sc = NI - 1;
    pt = 0;
    for (int s = 0; s < 7; s++) begin
      v = $signed(b[s*W +: W]);
      c = (v == NI) ? NI : v - pen_tab[a][s];
      if (c < NI) c = NI;
      if (c > sc) begin
        sc = c;
        pt = s;
      end
    end
  endfunction

  function automatic logic [44:0] model(input logic [BW-1:0] bx, input logic [BW-1:0] by,
                                       input logic [BW-1:0] bz);
    int sx, sy, sz, px, py, pz;
    eval_axis(bx, 0, sx, px);
    eval_axis(by, 1, sy, py);
    eval_axis(bz, 2, sz, pz);
    return {W'(sx), W'(sy), W'(sz), 3'(px), 3'(py), 3'(pz)};
  endfunction

  function automatic logic [W-1:0] rnd_slot();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return W'(NI);
    if (r == 1) return W'(NI + $urandom_range(0, 5));
    return W'($urandom);
  endfunction

  // One cycle: inputs already driven at the negedge; samples, scores, advances.
  task automatic step();
    logic [44:0] obs;
    #1;
    obs = {ix_out, iy_out, iz_out, tb_x, tb_y, tb_z};
    if (hold_v) begin
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_hold", 64'(obs), 64'(hold_d));
    end
    if (out_valid && out_ready) begin
      check("queue_nonempty", 64'(expq.size() != 0), 64'(1));
      if (expq.size() != 0) check("result", 64'(obs), 64'(expq.pop_front()));
      n_out++;
    end
    if (in_valid && in_ready) begin
      expq.push_back(model(nb_x, nb_y, nb_z));
      n_acc++;
    end
    hold_v = out_valid && !out_ready;
    hold_d = obs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send1(input logic [BW-1:0] bx, input logic [BW-1:0] by, input logic [BW-1:0] bz);
    nb_x = bx; nb_y = by; nb_z = bz;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check("accept_ready", 64'(in_ready), 64'(1));
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1 check("lat1_valid", 64'(out_valid), 64'(0));
    @(posedge clk); @(negedge clk);
    #1 check("lat2_valid", 64'(out_valid), 64'(1));
  endtask

  initial begin
    int sent;
    int got;
    int cyc;
    logic saw_low;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1 check("reset_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_outputs", 64'({ix_out, iy_out, iz_out, tb_x, tb_y, tb_z}), 64'(0));
    @(negedge clk);

    // All-zero neighbours: same-axis extension wins on each axis
    send1(bus_fill(0), bus_fill(0), bus_fill(0));
    check("t1_ix", 64'(ix_out), 64'(W'(-2)));
    check("t1_tbx", 64'(tb_x), 64'(4));
    check("t1_iy", 64'(iy_out), 64'(W'(-2)));
    check("t1_tby", 64'(tb_y), 64'(5));
    check("t1_iz", 64'(iz_out), 64'(W'(-2)));
    check("t1_tbz", 64'(tb_z), 64'(6));
    @(posedge clk); @(negedge clk);
    #1 check("t1_drained", 64'(out_valid), 64'(0));
    @(negedge clk);

    // Tie between M (10-4) and Ix (8-2) goes to index 0
    send1(set_slot(set_slot(bus_fill(NI), 0, 10), 4, 8), bus_fill(NI), bus_fill(NI));
    check("t2_ix", 64'(ix_out), 64'(W'(6)));
    check("t2_tbx", 64'(tb_x), 64'(0));
    @(posedge clk); @(negedge clk);

    // Saturation just above minus infinity
    send1(set_slot(bus_fill(NI), 0, -2046), bus_fill(NI), bus_fill(NI));
    check("t3a_ix", 64'(ix_out), 64'(W'(NI)));
    check("t3a_tbx", 64'(tb_x), 64'(0));
    check("t3a_iy", 64'(iy_out), 64'(W'(NI)));
    @(posedge clk); @(negedge clk);

    send1(bus_fill(NI), bus_fill(NI), bus_fill(NI));
    check("t3b_ix", 64'(ix_out), 64'(W'(NI)));
    check("t3b_tbx", 64'(tb_x), 64'(0));
    check("t3b_tbz", 64'(tb_z), 64'(0));
    @(posedge clk); @(negedge clk);

    // Backpressure: five inputs, downstream stalled for cycles 1-4
    sent = 0; got = 0; saw_low = 1'b0;
    nb_y = bus_fill(NI); nb_z = bus_fill(NI);
    for (int c = 1; c <= 12; c++) begin
      in_valid  = (sent < 5);
      nb_x      = set_slot(bus_fill(NI), 0, 100 + sent);
      out_ready = (c > 4);
      #1;
      if (c == 3) begin
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_two_accepted", 64'(sent), 64'(2));
      end
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) begin
        check("bp_order_ix", 64'(ix_out), 64'(W'(96 + got)));
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    check("bp_all_out", 64'(got), 64'(5));
    check("bp_saw_stall", 64'(saw_low), 64'(1));
    check("bp_queue_empty", 64'(expq.size()), 64'(0));

    // Reset with two transactions in flight
    out_ready = 1'b1; in_valid = 1'b1;
    nb_x = set_slot(bus_fill(NI), 0, 1);
    step();
    nb_x = set_slot(bus_fill(NI), 0, 2);
    step();
    #2 rst_n = 1'b0;
    #1 check("rst_mid_out_valid", 64'(out_valid), 64'(0));
    in_valid = 1'b0;
    expq.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send1(set_slot(bus_fill(NI), 0, 50), bus_fill(NI), bus_fill(NI));
    check("rst_new_ix", 64'(ix_out), 64'(W'(46)));
    check("rst_new_tbx", 64'(tb_x), 64'(0));
    @(posedge clk); @(negedge clk);
    #1 check("rst_single_out", 64'(out_valid), 64'(0));
    @(negedge clk);

    // Random stream with random valid and ready
    n_acc = 0; n_out = 0; cyc = 0;
    while (n_acc < 1000 && cyc < 10000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int s = 0; s < 7; s++) begin
        nb_x[s*W +: W] = rnd_slot();
        nb_y[s*W +: W] = rnd_slot();
        nb_z[s*W +: W] = rnd_slot();
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("rand_accepted", 64'(n_acc), 64'(1000));
    check("rand_delivered", 64'(n_out), 64'(n_acc));
    check("rand_queue_empty", 64'(expq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
